// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared sizing and legality helpers for elastic pipeline blocks
// Revision : 1.0
// ============================================================================
package pipe_pkg;

  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

  function automatic bit params_ok(input int width, input int depth);
    return (width >= 1) && (depth >= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// ============================================================================
// pipe_skid_slot : one elastic stage with a main/skid register pair
// Revision       : 1.0
// ============================================================================
module pipe_skid_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_xfer;
  logic             out_xfer;

  // Ready depends only on registered skid state, so it never sees out_ready.
  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;

  always_comb begin
    in_xfer     = in_valid && !skid_v_q;
    out_xfer    = main_v_q && out_ready;
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (out_xfer && skid_v_q) begin
      main_v_d    = 1'b1;
      main_data_d = skid_data_q;
      skid_v_d    = in_xfer;
      if (in_xfer) skid_data_d = in_data;
    end else if (in_xfer && (!main_v_q || out_xfer)) begin
      main_v_d    = 1'b1;
      main_data_d = in_data;
    end else if (in_xfer) begin
      skid_v_d    = 1'b1;
      skid_data_d = in_data;
    end else if (out_xfer) begin
      main_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_elastic_chain.sv
`default_nettype none
// ============================================================================
// pipe_elastic_chain : DEPTH skid-buffered stages; PIPE_OCC_EN adds occupancy
// Revision           : 1.0
// ============================================================================
module pipe_elastic_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        flush,
  output logic [occ_width(DEPTH)-1:0] occ
);

  logic [DEPTH:0]   stg_valid;
  logic [DEPTH:0]   stg_ready;
  logic [WIDTH-1:0] stg_data [DEPTH+1];

  generate
    if (!params_ok(WIDTH, DEPTH)) begin : g_bad_params
      $error("pipe_elastic_chain: WIDTH and DEPTH must both be >= 1");
    end
  endgenerate

  assign stg_valid[0]     = in_valid;
  assign stg_data[0]      = in_data;
  assign in_ready         = stg_ready[0];
  assign stg_ready[DEPTH] = out_ready;
  assign out_valid        = stg_valid[DEPTH];
  assign out_data         = stg_data[DEPTH];

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      pipe_skid_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (stg_valid[k]),
        .in_ready  (stg_ready[k]),
        .in_data   (stg_data[k]),
        .out_valid (stg_valid[k+1]),
        .out_ready (stg_ready[k+1]),
        .out_data  (stg_data[k+1])
      );
    end
  endgenerate

`ifdef PIPE_OCC_EN
  localparam int              OCC_W   = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = 1;

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             occ_in, occ_out;

  // Flush wins over any transfer in the same cycle.
  always_comb begin
    occ_in  = in_valid && in_ready;
    occ_out = out_valid && out_ready;
    occ_d   = occ_q;
    if (flush)                  occ_d = '0;
    else if (occ_in && !occ_out) occ_d = occ_q + OCC_ONE;
    else if (occ_out && !occ_in) occ_d = occ_q - OCC_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occ = occ_q;
`else
  assign occ = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_elastic_chain.sv
`default_nettype none
// ============================================================================
// tb_pipe_elastic_chain : queue-scoreboard bench, DEPTH=3/WIDTH=32 and 1/1
// Revision              : 1.0
// ============================================================================
module tb_pipe_elastic_chain;

  localparam int W = 32;
  localparam int D = 3;
`ifdef PIPE_OCC_EN
  localparam bit OCC_EN = 1'b1;
`else
  localparam bit OCC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, flush;
  logic [W-1:0] in_data, out_data;
  logic [2:0]   occ;

  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush;
  logic [0:0]   s_in_data, s_out_data;
  logic [1:0]   s_occ;

  pipe_elastic_chain #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occ(occ)
  );

  pipe_elastic_chain #(.WIDTH(1), .DEPTH(1)) u_dut_small (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .flush(s_flush), .occ(s_occ)
  );

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           s_outs = 0;
  bit           seen_dead = 1'b0;
  logic [W-1:0] exp_q [$];
  logic [0:0]   s_q [$];
  int           out_cyc [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Main scoreboard: the reference is an unbounded FIFO of accepted words.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      check("occ", {61'd0, occ}, OCC_EN ? exp_q.size() : 0);
      check("out_valid_without_entry", {63'd0, out_valid && exp_q.size() == 0}, 64'd0);
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        if (out_data == 32'h0000_DEAD) seen_dead = 1'b1;
        if (exp_q.size() != 0) check("data_order", out_data, exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      s_q.delete();
    end else begin
      check("s_occ", {62'd0, s_occ}, OCC_EN ? s_q.size() : 0);
      check("s_out_valid_without_entry", {63'd0, s_out_valid && s_q.size() == 0}, 64'd0);
      if (s_out_valid && s_out_ready) begin
        s_outs++;
        if (s_q.size() != 0) check("s_data_order", s_out_data, s_q.pop_front());
      end
      if (s_in_valid && s_in_ready) s_q.push_back(s_in_data);
    end
  end

  task automatic measure_latency(input logic [W-1:0] word, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = word;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
  endtask

  task automatic push_words(input int n, input logic [W-1:0] base);
    int acc = 0;
    int tries = 0;
    while (acc < n && tries < 30) begin
      in_valid = 1'b1;
      in_data  = base + W'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      tries++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("push_words_accepted", acc, n);
  endtask

  task automatic drain_main(input string name);
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    int base;
    int acc;
    int span;
    int r;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_flush = 1'b0;
    step();
    step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_occ", {61'd0, occ}, 64'd0);
    rst = 1'b0;
    step();

    // Latency and back-to-back streaming with out_ready held high.
    measure_latency(32'hA5A5_0001, lat);
    check("latency", lat, D);
    check("latency_data", out_data, 32'hA5A5_0001);
    step();
    base = out_cyc.size();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_1000 + W'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (D + 4) step();
    check("stream_count", out_cyc.size() - base, 10);
    span = (out_cyc.size() >= base + 10) ? out_cyc[base+9] - out_cyc[base] : -1;
    check("stream_consecutive", span, 9);

    // Fill with the output stalled: capacity is 2*DEPTH.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_2000 + W'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("fill_accepted", acc, 2 * D);
    check("fill_in_ready", {63'd0, in_ready}, 64'd0);
    check("fill_occ", {61'd0, occ}, OCC_EN ? 2 * D : 0);
    base = out_cyc.size();
    out_ready = 1'b1;
    r = 0;
    while (!in_ready && r < 20) begin
      step();
      r++;
    end
    check("ready_reassert_within_depth", {63'd0, r <= D}, 64'd1);
    drain_main("fill_drained");
    check("fill_out_count", out_cyc.size() - base, 2 * D);

    // Flush with four entries held and a concurrent offer of 0xDEAD.
    out_ready = 1'b0;
    push_words(4, 32'h0000_3000);
    seen_dead = 1'b0;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0000_DEAD;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_occ", {61'd0, occ}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (2 * D + 2) step();
    check("flush_dead_never_out", {63'd0, seen_dead}, 64'd0);
    check("flush_stays_empty", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset in the middle of a cycle with three entries held.
    out_ready = 1'b0;
    push_words(3, 32'h0000_4000);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_out_data", out_data, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_occ", {61'd0, occ}, 64'd0);
    step();
    rst = 1'b0;
    step();
    measure_latency(32'hB00B_0001, lat);
    check("post_reset_latency", lat, D);
    check("post_reset_data", out_data, 32'hB00B_0001);
    step();

    // Random traffic with occasional flush against the queue model.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      in_data   = $urandom;
      step();
    end
    flush = 1'b0;
    drain_main("random_drained");

    // DEPTH=1, WIDTH=1 instance: capacity, latency and alternating stall.
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = 1'(i);
      @(negedge clk);
      if (s_in_ready) acc++;
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    check("small_capacity", acc, 2);
    check("small_full_in_ready", {63'd0, s_in_ready}, 64'd0);
    s_out_ready = 1'b1;
    repeat (4) step();
    check("small_drained", s_q.size(), 0);

    s_in_valid = 1'b1;
    s_in_data  = 1'b1;
    step();
    s_in_valid = 1'b0;
    check("small_latency_valid", {63'd0, s_out_valid}, 64'd1);
    check("small_latency_data", {63'd0, s_out_data}, 64'd1);
    step();
    step();

    base = s_outs;
    for (int i = 0; i < 20; i++) begin
      s_out_ready = (i % 2 == 1);
      s_in_valid  = 1'b1;
      s_in_data   = 1'($urandom);
      step();
    end
    s_in_valid  = 1'b0;
    check("small_half_throughput", s_outs - base, 10);
    s_out_ready = 1'b1;
    repeat (4) step();
    check("small_final_drained", s_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
